// File: rtl/ddr_chk_pkg.sv
// Shared types and constants for the DDR pattern checker.
// The pattern selection macro DDR_CHK_LFSR_EN is consumed by ddr_chk_pattern.
package ddr_chk_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      SETTLE = 3'd2,
      READ   = 3'd3,
      DONE   = 3'd4
   } chk_state_t;

   // Galois taps for x^32 + x^22 + x^2 + x + 1 in right-shift form
   localparam logic [31:0] LFSR_POLY = 32'h80200003;

   localparam int CNT_W = 16;

endpackage

// File: rtl/ddr_chk_pattern.sv
// Deterministic word generator; two copies keep the write and expected streams in lockstep.
// DDR_CHK_LFSR_EN defined selects a 32-bit Galois LFSR, otherwise the word increments.
module ddr_chk_pattern
   import ddr_chk_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   output logic [31:0] word
);

   logic [31:0] word_next;

`ifdef DDR_CHK_LFSR_EN
   always_comb begin
      word_next = {1'b0, word[31:1]};
      if (word[0]) begin
         word_next = word_next ^ LFSR_POLY;
      end
   end
`else
   always_comb begin
      word_next = word + 32'd1;
   end
`endif

   // load wins over step so a new pass always restarts from SEED
   always_ff @(posedge clk) begin
      if (rst) begin
         word <= SEED;
      end else if (load) begin
         word <= SEED;
      end else if (step) begin
         word <= word_next;
      end
   end

endmodule

// File: rtl/ddr_pattern_checker.sv
// Write/settle/read-back/compare self-test for the DDR3 user FIFO path.
// Pattern is selected by DDR_CHK_LFSR_EN (LFSR when defined, incrementing otherwise).
module ddr_pattern_checker
   import ddr_chk_pkg::*;
#(
   parameter int          DATA_WIDTH     = 16,
   parameter int          WORD_CNT       = 1024,
   parameter int          SETTLE_CYCLES  = 512,
   parameter int          TIMEOUT_CYCLES = 65535,
   parameter logic [31:0] SEED           = 32'h1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  calib_done,
   input  logic                  start,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_mem_enable,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  timeout,
   output logic [15:0]           err_cnt,
   output logic [15:0]           first_err_idx
);

   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] WORD_N       = CNT_W'(WORD_CNT);
   localparam logic [CNT_W-1:0] WORD_LAST    = CNT_W'(WORD_CNT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]      DATA_MASK    = 32'((64'd1 << DATA_WIDTH) - 64'd1);

   chk_state_t       state;
   chk_state_t       state_next;

   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] settle_cnt;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] cmp_cnt;
   logic [CNT_W-1:0] tmo_cnt;
   logic             cmp_pending;
   logic             have_err;
   logic             pass_q;

   logic             start_ok;
   logic             cmp_fire;
   logic             mismatch;
   logic             last_cmp;
   logic             tmo_hit;

   logic [31:0]      wr_word;
   logic [31:0]      exp_word;
   logic             unused_word_bits;

   ddr_chk_pattern #(
      .SEED (SEED)
   ) wr_gen (
      .clk  (clk),
      .rst  (rst),
      .load (start_ok),
      .step (state == WRITE),
      .word (wr_word)
   );

   ddr_chk_pattern #(
      .SEED (SEED)
   ) exp_gen (
      .clk  (clk),
      .rst  (rst),
      .load (start_ok),
      .step (cmp_fire),
      .word (exp_word)
   );

   // Only the low DATA_WIDTH bits of the write stream reach the FIFO
   assign unused_word_bits = ^wr_word;

   always_comb begin
      start_ok = (state == IDLE) && start && calib_done;
      cmp_fire = (state == READ) && cmp_pending;
      mismatch = cmp_fire && (((exp_word ^ 32'(rd_data)) & DATA_MASK) != 32'd0);
      last_cmp = cmp_fire && (cmp_cnt == WORD_LAST);
      tmo_hit  = (state == READ) && !cmp_fire && (tmo_cnt == TIMEOUT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      wr_data    = '0;
      rd_en      = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      pass       = pass_q;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start_ok) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            wr_en   = 1'b1;
            wr_data = wr_word[DATA_WIDTH-1:0];
            if (wr_cnt == WORD_LAST) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_next = READ;
            end
         end
         READ: begin
            rd_en = rd_valid && (issued < WORD_N);
            if (last_cmp || tmo_hit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            pass       = (err_cnt == 16'd0) && !timeout;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Result registers survive IDLE so software can read the last pass;
   // only an accepted start or rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt        <= '0;
         settle_cnt    <= '0;
         issued        <= '0;
         cmp_cnt       <= '0;
         tmo_cnt       <= '0;
         cmp_pending   <= 1'b0;
         have_err      <= 1'b0;
         pass_q        <= 1'b0;
         timeout       <= 1'b0;
         rd_mem_enable <= 1'b0;
         err_cnt       <= '0;
         first_err_idx <= '0;
      end else begin
         cmp_pending <= rd_en;
         if (start_ok) begin
            wr_cnt        <= '0;
            settle_cnt    <= '0;
            issued        <= '0;
            cmp_cnt       <= '0;
            tmo_cnt       <= '0;
            have_err      <= 1'b0;
            pass_q        <= 1'b0;
            timeout       <= 1'b0;
            rd_mem_enable <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
         end
         if (state == WRITE) begin
            wr_cnt <= wr_cnt + CNT_ONE;
         end
         if (state == SETTLE) begin
            settle_cnt <= settle_cnt + CNT_ONE;
            if (settle_cnt == SETTLE_LAST) begin
               rd_mem_enable <= 1'b1;
               tmo_cnt       <= '0;
            end
         end
         if (rd_en) begin
            issued <= issued + CNT_ONE;
         end
         // A separate first-error flag keeps first_err_idx correct even if err_cnt is nonzero at entry
         if (cmp_fire) begin
            cmp_cnt <= cmp_cnt + CNT_ONE;
            tmo_cnt <= '0;
            if (mismatch) begin
               if (err_cnt != 16'hFFFF) begin
                  err_cnt <= err_cnt + 16'd1;
               end
               if (!have_err) begin
                  have_err      <= 1'b1;
                  first_err_idx <= cmp_cnt;
               end
            end
         end else if (state == READ) begin
            tmo_cnt <= tmo_cnt + CNT_ONE;
         end
         if (tmo_hit) begin
            timeout <= 1'b1;
         end
         if (state == DONE) begin
            pass_q <= (err_cnt == 16'd0) && !timeout;
         end
      end
   end

endmodule

// File: tb/tb_ddr_pattern_checker.sv
// Self-checking bench for ddr_pattern_checker with a loop-back FIFO/memory model.
// Expected results come from the pattern formula and the injected corruption table.
module tb_ddr_pattern_checker;

   localparam int          DW      = 16;
   localparam int          NWORDS  = 16;
   localparam int          NSETTLE = 8;
   localparam int          NTMO    = 100;
   localparam logic [31:0] SEED    = 32'h000000FF;

   logic          clk = 1'b0;
   logic          rst;
   logic          calib_done;
   logic          start;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_mem_enable;
   logic          rd_en;
   logic [DW-1:0] rd_data = '0;
   logic          rd_valid = 1'b0;
   logic          busy;
   logic          done;
   logic          pass;
   logic          timeout;
   logic [15:0]   err_cnt;
   logic [15:0]   first_err_idx;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] mem     [0:63];
   logic          bad_en  [0:63];
   logic [DW-1:0] bad_val [0:63];
   logic [6:0]    wr_ptr = '0;
   logic [6:0]    rd_ptr = '0;
   logic          rd_allow = 1'b1;
   logic          rd_gaps  = 1'b0;

   ddr_pattern_checker #(
      .DATA_WIDTH     (DW),
      .WORD_CNT       (NWORDS),
      .SETTLE_CYCLES  (NSETTLE),
      .TIMEOUT_CYCLES (NTMO),
      .SEED           (SEED)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .calib_done    (calib_done),
      .start         (start),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .rd_mem_enable (rd_mem_enable),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout),
      .err_cnt       (err_cnt),
      .first_err_idx (first_err_idx)
   );

   always #5 clk = ~clk;

   // Loop-back memory: every written word is stored, read words can be overridden
   always @(posedge clk) begin
      if (rst || (start && calib_done && !busy)) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[5:0]] <= wr_data;
            wr_ptr           <= wr_ptr + 7'd1;
         end
         if (rd_en) begin
            rd_data <= bad_en[rd_ptr[5:0]] ? bad_val[rd_ptr[5:0]] : mem[rd_ptr[5:0]];
            rd_ptr  <= rd_ptr + 7'd1;
         end
      end
   end

   always @(negedge clk) begin
      rd_valid <= rd_allow && rd_mem_enable && (rd_ptr < wr_ptr) &&
                  (!rd_gaps || ($urandom_range(0, 2) != 0));
   end

   function automatic logic [DW-1:0] model_word(input int k);
      logic [31:0] s;
`ifdef DDR_CHK_LFSR_EN
      s = SEED;
      for (int i = 0; i < k; i++) begin
         s = s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
      end
`else
      s = SEED + 32'(k);
`endif
      return s[DW-1:0];
   endfunction

   task automatic clear_corruption();
      for (int i = 0; i < 64; i++) begin
         bad_en[i]  = 1'b0;
         bad_val[i] = '0;
      end
   endtask

   task automatic model_errors(output int exp_err, output int exp_first);
      exp_err   = 0;
      exp_first = 0;
      for (int i = NWORDS - 1; i >= 0; i--) begin
         if (bad_en[i] && (bad_val[i] != model_word(i))) begin
            exp_err++;
            exp_first = i;
         end
      end
   endtask

   task automatic run_pass(output bit got_done, output bit first_wr,
                           output bit pass_at_done, output bit busy_at_done);
      got_done     = 1'b0;
      pass_at_done = 1'b0;
      busy_at_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      first_wr = wr_en;
      for (int i = 0; i < 400; i++) begin
         if (done) begin
            got_done     = 1'b1;
            pass_at_done = pass;
            busy_at_done = busy;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      calib_done = 1'b1;
      start      = 1'b0;
      clear_corruption();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({wr_en, rd_en, busy, done, pass, timeout, rd_mem_enable} !== 7'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_ctrl got=%b want=0000000",
                  {wr_en, rd_en, busy, done, pass, timeout, rd_mem_enable});
      end
      n_cmp++;
      if ({err_cnt, first_err_idx, wr_data} !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_data err_cnt=%h first=%h wr_data=%h want all 0",
                  err_cnt, first_err_idx, wr_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_loopback();
      bit got, fw, pd, bd;
      clear_corruption();
      rd_gaps = 1'b0;
      run_pass(got, fw, pd, bd);
      n_cmp++;
      if (!got) begin n_bad++; $display("[TB] FAIL loop_done got=0 want=1"); end
      n_cmp++;
      if (fw !== 1'b1) begin n_bad++; $display("[TB] FAIL loop_first_wr got=%b want=1", fw); end
      n_cmp++;
      if (wr_ptr !== 7'(NWORDS)) begin
         n_bad++; $display("[TB] FAIL loop_wr_cycles got=%0d want=%0d", wr_ptr, NWORDS);
      end
      for (int i = 0; i < NWORDS; i++) begin
         n_cmp++;
         if (mem[i] !== model_word(i)) begin
            n_bad++; $display("[TB] FAIL loop_wr_data[%0d] got=%h want=%h", i, mem[i], model_word(i));
         end
      end
      n_cmp++;
      if ({pd, bd} !== 2'b11) begin n_bad++; $display("[TB] FAIL loop_pass_busy got=%b want=11", {pd, bd}); end
      n_cmp++;
      if ({err_cnt, first_err_idx, timeout} !== 33'd0) begin
         n_bad++; $display("[TB] FAIL loop_result err=%h first=%h tmo=%b want 0", err_cnt, first_err_idx, timeout);
      end
      @(negedge clk);
      n_cmp++;
      if ({done, busy, pass} !== 3'b001) begin
         n_bad++; $display("[TB] FAIL loop_after_done done/busy/pass got=%b want=001", {done, busy, pass});
      end
   endtask

   task automatic check_error_pass(input string name, input logic [15:0] preload_err);
      bit got, fw, pd, bd;
      int exp_err, exp_first;
      logic [15:0] exp_cnt;
      model_errors(exp_err, exp_first);
      exp_cnt = (32'(preload_err) + 32'(exp_err) > 32'hFFFF) ? 16'hFFFF : 16'(32'(preload_err) + 32'(exp_err));
      run_pass(got, fw, pd, bd);
      n_cmp++;
      if (!got) begin n_bad++; $display("[TB] FAIL %s_done got=0 want=1", name); end
      n_cmp++;
      if (err_cnt !== exp_cnt) begin
         n_bad++; $display("[TB] FAIL %s_err_cnt got=%h want=%h", name, err_cnt, exp_cnt);
      end
      n_cmp++;
      if (first_err_idx !== 16'(exp_first)) begin
         n_bad++; $display("[TB] FAIL %s_first_idx got=%0d want=%0d", name, first_err_idx, exp_first);
      end
      n_cmp++;
      if ((pd !== (exp_cnt == 16'd0)) || (timeout !== 1'b0)) begin
         n_bad++; $display("[TB] FAIL %s_pass got pass=%b tmo=%b want pass=%b tmo=0",
                           name, pd, timeout, exp_cnt == 16'd0);
      end
   endtask

   task automatic test_single_error();
      clear_corruption();
      bad_en[5]  = 1'b1;
      bad_val[5] = 16'h0000;
      check_error_pass("single", 16'd0);
   endtask

   task automatic test_random_errors();
      rd_gaps = 1'b1;
      for (int p = 0; p < 4; p++) begin
         clear_corruption();
         for (int i = 0; i < NWORDS; i++) begin
            bad_en[i]  = (p != 0) && ($urandom_range(0, 3) == 0);
            bad_val[i] = model_word(i) ^ DW'($urandom_range(1, 65535));
         end
         check_error_pass($sformatf("rand%0d", p), 16'd0);
      end
      rd_gaps = 1'b0;
   endtask

   task automatic test_timeout();
      int t_read, t_done;
      clear_corruption();
      rd_allow = 1'b0;
      t_read   = -1;
      t_done   = -1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 400 && t_done < 0; i++) begin
         if (rd_mem_enable && t_read < 0) t_read = i;
         if (done) t_done = i;
         else @(negedge clk);
      end
      n_cmp++;
      if ((t_read < 0) || (t_done < 0) || (t_done - t_read != NTMO)) begin
         n_bad++; $display("[TB] FAIL tmo_latency got=%0d want=%0d", t_done - t_read, NTMO);
      end
      n_cmp++;
      if ({timeout, pass, err_cnt} !== {1'b1, 1'b0, 16'd0}) begin
         n_bad++; $display("[TB] FAIL tmo_flags tmo=%b pass=%b err=%h want tmo=1 pass=0 err=0",
                           timeout, pass, err_cnt);
      end
      rd_allow = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_calib_gate();
      bit seen;
      calib_done = 1'b0;
      seen       = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) begin
         seen = seen | busy | wr_en;
         @(negedge clk);
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL calib_start_ignored got=1 want=0"); end
      calib_done = 1'b1;
      seen       = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | busy | wr_en;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("[TB] FAIL calib_late_run got=1 want=0"); end
   endtask

   task automatic test_reset_mid();
      bit got, fw, pd, bd, saw_done;
      clear_corruption();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && wr_ptr != 7'd7; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({wr_en, rd_en, busy, done, pass, timeout, rd_mem_enable, err_cnt, first_err_idx, wr_data} !== '0) begin
         n_bad++; $display("[TB] FAIL midrst_outputs ctrl=%b err=%h first=%h wr_data=%h want 0",
                           {wr_en, rd_en, busy, done, pass, timeout, rd_mem_enable},
                           err_cnt, first_err_idx, wr_data);
      end
      rst      = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         saw_done = saw_done | done;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_no_done got=1 want=0"); end
      run_pass(got, fw, pd, bd);
      n_cmp++;
      if ({got, pd} !== 2'b11) begin
         n_bad++; $display("[TB] FAIL midrst_rerun done/pass got=%b want=11", {got, pd});
      end
   endtask

   task automatic test_saturation();
      bit got, pd;
      int exp_err, exp_first;
      logic [15:0] exp_cnt;
      clear_corruption();
      for (int i = 0; i < NWORDS; i++) begin
         bad_en[i]  = 1'b1;
         bad_val[i] = ~model_word(i);
      end
      model_errors(exp_err, exp_first);
      exp_cnt = (32'hFFF8 + 32'(exp_err) > 32'hFFFF) ? 16'hFFFF : 16'(32'hFFF8 + 32'(exp_err));
      got = 1'b0;
      pd  = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && !(wr_ptr == 7'(NWORDS) && !wr_en); i++) @(negedge clk);
      force dut.err_cnt = 16'hFFF8;
      @(negedge clk);
      release dut.err_cnt;
      for (int i = 0; i < 400; i++) begin
         if (done) begin got = 1'b1; pd = pass; break; end
         @(negedge clk);
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("[TB] FAIL sat_done got=0 want=1"); end
      n_cmp++;
      if (err_cnt !== exp_cnt) begin n_bad++; $display("[TB] FAIL sat_err_cnt got=%h want=%h", err_cnt, exp_cnt); end
      n_cmp++;
      if ({pd, first_err_idx} !== {1'b0, 16'(exp_first)}) begin
         n_bad++; $display("[TB] FAIL sat_pass_first pass=%b first=%0d want pass=0 first=%0d", pd, first_err_idx, exp_first);
      end
   endtask

   task automatic test_back_to_back();
      bit got, fw, pd, bd, seen;
      clear_corruption();
      run_pass(got, fw, pd, bd);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      repeat (5) begin
         seen = seen | busy | wr_en;
         @(negedge clk);
      end
      n_cmp++;
      if ({got, seen} !== 2'b10) begin
         n_bad++; $display("[TB] FAIL b2b_start_in_done done/restarted got=%b want=10", {got, seen});
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_single_error();
      test_random_errors();
      test_timeout();
      test_calib_gate();
      test_reset_mid();
      test_saturation();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
